// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer slice.
// Holds the request op-code encoding, the aluOp select encoding seen by the
// external ALU, the sequencer state enum and the multiply iteration count.
package alu_pkg;

  localparam int DATA_W         = 8;
  localparam int MUL_ITERATIONS = 8;

  // Request op-codes as presented on i_op
  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_AND     = 3'b010,
    OP_XOR     = 3'b011,
    OP_SHL     = 3'b100,
    OP_SHR     = 3'b101,
    OP_MUL     = 3'b110,
    OP_ILLEGAL = 3'b111
  } op_e;

  // ALU function select; o_subShiftDir picks SUB/SHL when set, ADD/SHR when clear
  typedef enum logic [1:0] {
    ALU_ADDSUB = 2'b00,
    ALU_AND    = 2'b01,
    ALU_XOR    = 2'b10,
    ALU_SHIFT  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_READ,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response handshake plus the shared ALU bus of the sequencer.
//   slave  : sequencer side (takes requests, drives ALU controls, reads i_aluY)
//   master : requester + ALU side (drives requests and the ALU result bus)
// Request : i_valid, o_ready, i_op[2:0], i_opA[7:0], i_opB[7:0]
// Response: o_valid, o_result[7:0], o_negative, o_nZero
// ALU bus : o_aluA, o_aluB, o_aluOp[1:0], o_subShiftDir, o_aluWr, o_aluNoe (active-low),
//           i_aluY[7:0], i_aluNegative, i_aluNZero
interface alu_sequencer_if;

  logic                       i_valid;
  logic                       o_ready;
  logic [2:0]                 i_op;
  logic [alu_pkg::DATA_W-1:0] i_opA;
  logic [alu_pkg::DATA_W-1:0] i_opB;

  logic                       o_valid;
  logic [alu_pkg::DATA_W-1:0] o_result;
  logic                       o_negative;
  logic                       o_nZero;

  logic [alu_pkg::DATA_W-1:0] o_aluA;
  logic [alu_pkg::DATA_W-1:0] o_aluB;
  logic [1:0]                 o_aluOp;
  logic                       o_subShiftDir;
  logic                       o_aluWr;
  logic                       o_aluNoe;
  logic [alu_pkg::DATA_W-1:0] i_aluY;
  logic                       i_aluNegative;
  logic                       i_aluNZero;

  modport slave (
    input  i_valid, i_op, i_opA, i_opB, i_aluY, i_aluNegative, i_aluNZero,
    output o_ready, o_valid, o_result, o_negative, o_nZero,
           o_aluA, o_aluB, o_aluOp, o_subShiftDir, o_aluWr, o_aluNoe
  );

  modport master (
    output i_valid, i_op, i_opA, i_opB, i_aluY, i_aluNegative, i_aluNZero,
    input  o_ready, o_valid, o_result, o_negative, o_nZero,
           o_aluA, o_aluB, o_aluOp, o_subShiftDir, o_aluWr, o_aluNoe
  );

endinterface

// File: rtl/alu_sequencer.sv
// Sequencer that runs one request at a time through an external ALU.
// Each ALU step is EXEC (load ALU result register) then READ (ALU drives the
// bus, result captured). MUL is shift-and-add over MUL_ITERATIONS iterations
// of two ALU steps each; op 111 skips the ALU and answers with zeros.
// Ports: i_clk, i_reset (synchronous, active-high), bus (alu_sequencer_if.slave).
module alu_sequencer
  import alu_pkg::*;
(
  input logic            i_clk,
  input logic            i_reset,
  alu_sequencer_if.slave bus
);

  localparam int                ITER_W    = $clog2(MUL_ITERATIONS);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MUL_ITERATIONS - 1);

  seq_state_e        state_q, state_d;
  op_e               op_q;
  // For MUL, a_q doubles as the multiplicand M and b_q as the multiplier Q
  logic [DATA_W-1:0] a_q, b_q, p_q;
  logic [DATA_W-1:0] result_q;
  logic              neg_q, nz_q;
  logic [ITER_W-1:0] iter_q;
  // phase_q: 0 = accumulate step, 1 = multiplicand shift step
  logic              phase_q;
  logic              mul_last;

  logic [DATA_W-1:0] alu_a, alu_b;
  alu_op_e           alu_op;
  logic              alu_dir;

  assign mul_last = phase_q && (iter_q == LAST_ITER);

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.i_valid) state_d = (bus.i_op == OP_ILLEGAL) ? S_DONE : S_EXEC;
      S_EXEC:  state_d = S_READ;
      S_READ:  state_d = (op_q == OP_MUL && !mul_last) ? S_EXEC : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operands and function select only matter while the ALU register loads
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = ALU_ADDSUB;
    alu_dir = 1'b0;
    if (state_q == S_EXEC) begin
      case (op_q)
        OP_ADD: begin alu_a = a_q; alu_b = b_q; end
        OP_SUB: begin alu_a = a_q; alu_b = b_q; alu_dir = 1'b1; end
        OP_AND: begin alu_a = a_q; alu_b = b_q; alu_op = ALU_AND; end
        OP_XOR: begin alu_a = a_q; alu_b = b_q; alu_op = ALU_XOR; end
        OP_SHL: begin alu_a = a_q; alu_b = DATA_W'(b_q[2:0]); alu_op = ALU_SHIFT; alu_dir = 1'b1; end
        OP_SHR: begin alu_a = a_q; alu_b = DATA_W'(b_q[2:0]); alu_op = ALU_SHIFT; end
        OP_MUL: begin
          if (phase_q) begin
            alu_a   = a_q;
            alu_b   = DATA_W'(1);
            alu_op  = ALU_SHIFT;
            alu_dir = 1'b1;
          end else begin
            alu_a = p_q;
            alu_b = b_q[0] ? a_q : '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Request latch, MUL iteration state and the held response registers.
  // The response registers change only on the edge that enters DONE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      iter_q   <= '0;
      phase_q  <= 1'b0;
      result_q <= '0;
      neg_q    <= 1'b0;
      nz_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_valid) begin
            op_q    <= op_e'(bus.i_op);
            a_q     <= bus.i_opA;
            b_q     <= bus.i_opB;
            p_q     <= '0;
            iter_q  <= '0;
            phase_q <= 1'b0;
            if (bus.i_op == OP_ILLEGAL) begin
              result_q <= '0;
              neg_q    <= 1'b0;
              nz_q     <= 1'b0;
            end
          end
        end
        S_READ: begin
          if (op_q == OP_MUL) begin
            if (!phase_q) begin
              p_q     <= bus.i_aluY;
              phase_q <= 1'b1;
            end else begin
              a_q     <= bus.i_aluY;
              b_q     <= b_q >> 1;
              phase_q <= 1'b0;
              iter_q  <= iter_q + 1'b1;
              // The final shift step's flags describe M, so report P instead
              if (iter_q == LAST_ITER) begin
                result_q <= p_q;
                neg_q    <= p_q[DATA_W-1];
                nz_q     <= |p_q;
              end
            end
          end else begin
            result_q <= bus.i_aluY;
            neg_q    <= bus.i_aluNegative;
            nz_q     <= bus.i_aluNZero;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready       = (state_q == S_IDLE);
  assign bus.o_valid       = (state_q == S_DONE);
  assign bus.o_aluWr       = (state_q == S_EXEC);
  assign bus.o_aluNoe      = (state_q != S_READ);
  assign bus.o_result      = result_q;
  assign bus.o_negative    = neg_q;
  assign bus.o_nZero       = nz_q;
  assign bus.o_aluA        = alu_a;
  assign bus.o_aluB        = alu_b;
  assign bus.o_aluOp       = alu_op;
  assign bus.o_subShiftDir = alu_dir;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have i_clk  input  1  clock; all state changes on its rising edge.
REQ-002 SHALL have i_reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have i_valid  input  1  request valid.
REQ-004 SHALL have o_ready  output  1  request accepted when i_valid & o_ready at a clock edge.
REQ-005 SHALL have i_op  input  3  000 ADD, 001 SUB, 010 AND, 011 XOR, 100 SHL, 101 SHR, 110 MUL (low byte), 111 illegal.
REQ-006 SHALL have i_opA / i_opB  input  8 each  operands; shift amount = i_opB[2:0].
REQ-007 SHALL have o_valid  output  1  one-cycle response pulse.
REQ-008 SHALL have o_result  output  8; o_negative  output  1; o_nZero  output  1; all held until the next response.
REQ-009 SHALL have o_aluA, o_aluB  output  8  ALU operands.
REQ-010 SHALL have o_aluOp  output  2 and o_subShiftDir  output  1  ALU operation select.
REQ-011 SHALL have o_aluWr  output  1  ALU result-register load, and o_aluNoe  output  1  ALU bus drive enable, active-low.
REQ-012 SHALL have i_aluY  input  8  ALU bus; i_aluNegative, i_aluNZero  input  1  ALU flags.

Function
REQ-013 States SHALL be IDLE, EXEC, READ, DONE. o_ready SHALL be 1 only in IDLE.
REQ-014 On accept, the sequencer SHALL latch op and operands, then go IDLE->EXEC (op 000-110) or IDLE->DONE (op 111).
REQ-015 In EXEC, o_aluWr SHALL be 1 for exactly one cycle, with operands and control driven as follows:
- ADD: aluOp 00, dir 0
- SUB: aluOp 00, dir 1
- AND: aluOp 01, dir 0
- XOR: aluOp 10, dir 0
- SHL: aluOp 11, dir 1
- SHR: aluOp 11, dir 0
REQ-016 READ SHALL follow EXEC: o_aluNoe=0 for one cycle; i_aluY, i_aluNegative and i_aluNZero are captured at that cycle's end edge.
REQ-017 Outside READ, o_aluNoe SHALL be 1; outside EXEC, o_aluWr SHALL be 0.
REQ-018 Single-op latency: accept at edge E0; o_valid=1 in the cycle after E2, i.e. DONE, with o_result and flags valid; IDLE again after E3.
REQ-019 MUL SHALL run 8 iterations, fixed latency, with P=0, M=A and Q=B at start. Each iteration takes 4 cycles:
- EXEC/READ: ADD P + (Q[0] ? M : 0x00) -> P.
- EXEC/READ: SHL M by 1 -> M.
- Then Q shifts right internally.
REQ-020 MUL response SHALL come in DONE after 32 ALU cycles: o_valid 33 cycles after the accept edge, o_result=P mod 256, o_negative=P[7], o_nZero=|P.
REQ-021 Illegal op 111 SHALL produce no ALU activity. o_valid SHALL assert in the cycle after accept, with o_result=0x00, o_negative=0, o_nZero=0.
REQ-022 i_valid while busy SHALL be ignored, with no queuing; i_valid in DONE SHALL NOT be accepted until IDLE.
REQ-023 Arithmetic SHALL be 8-bit with carry/overflow discarded; shifts by 0 SHALL return A unchanged.

Reset
REQ-024 i_reset SHALL force state IDLE at the next edge, including mid-operation; the pending operation is dropped with no o_valid.
REQ-025 After reset:
- o_ready=1, o_valid=0
- o_result=0x00, o_negative=0, o_nZero=0
- o_aluWr=0, o_aluNoe=1
- o_aluA=o_aluB=0x00, o_aluOp=00, o_subShiftDir=0
REQ-026 Reset SHALL take priority over a simultaneous accept.

Structure
REQ-027 Shared package alu_pkg SHALL hold the op-code enum, the ALU aluOp encodings, the sequencer state enum and MUL_ITERATIONS=8.
REQ-028 The sequencer SHALL be a single module with no sub-modules; the MUL iteration counter and phase bit SHALL live inside it.

Verification (bench pairs DUT with the existing ALU model on the shared bus)
REQ-029 ADD 0x7F+0x01 -> o_result 0x80, neg=1, nZ=1, o_valid exactly 3 cycles after accept, aluWr one cycle, noe low one cycle.
REQ-030 SUB 0x05-0x05 -> 0x00, neg=0, nZ=0; AND 0xF0&0x3C -> 0x30; XOR 0xFF^0x0F -> 0xF0.
REQ-031 SHL 0x81 by 1 -> 0x02; SHR 0x80 by 7 -> 0x01; SHR 0x5A by 0 -> 0x5A.
REQ-032 MUL 0x0D*0x0B -> 0x8F, neg=1, nZ=1, o_valid 33 cycles after accept; MUL 0x10*0x10 -> 0x00, nZ=0.
REQ-033 i_reset for one cycle 10 cycles into MUL -> next cycle o_ready=1, o_aluNoe=1, o_aluWr=0, no o_valid; a following ADD 0x01+0x02 -> 0x03.
REQ-034 Op 111 -> o_valid the cycle after accept, result 0x00, no aluWr/noe activity; i_valid held high while busy -> exactly one response per accept.
